// File: rtl/alu_mul_seq.sv
// Sequential shift-and-add multiplier that borrows an external ALU for every
// addition and left shift; only the multiplier right-shift is done locally.
module alu_mul_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_control,
    input  logic [31:0] alu_result,
    input  logic        alu_zero
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_SHF,
        S_DONE
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SLL = 3'b101;

    state_t      state_q, state_d;
    logic [31:0] p_q, p_d;
    logic [31:0] m_q, m_d;
    logic [31:0] q_q, q_d;
    logic [31:0] product_q, product_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [2:0]  alu_ctrl_q, alu_ctrl_d;

    // The ALU flag carries no information this sequencer needs.
    logic unused_alu_zero;
    assign unused_alu_zero = alu_zero;

    always_comb begin
        state_d   = state_q;
        p_d       = p_q;
        m_d       = m_q;
        q_d       = q_q;
        product_d = product_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    p_d     = '0;
                    m_d     = op_a;
                    q_d     = op_b;
                    state_d = (op_b != '0) ? S_ADD : S_DONE;
                end
            end
            S_ADD: begin
                if (q_q[0]) begin
                    p_d = alu_result;
                end
                state_d = S_SHF;
            end
            S_SHF: begin
                m_d     = alu_result;
                q_d     = q_q >> 1;
                state_d = (q_d == '0) ? S_DONE : S_ADD;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_DONE) begin
            product_d = p_d;
        end

        // Outputs are decoded from the next state so they leave a register
        // already aligned with the state they describe.
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        alu_a_d    = '0;
        alu_b_d    = '0;
        alu_ctrl_d = ALU_ADD;
        case (state_d)
            S_ADD: begin
                alu_a_d    = p_d;
                alu_b_d    = m_d;
                alu_ctrl_d = ALU_ADD;
            end
            S_SHF: begin
                alu_a_d    = m_d;
                alu_b_d    = 32'd1;
                alu_ctrl_d = ALU_SLL;
            end
            default: begin
                alu_a_d    = '0;
                alu_b_d    = '0;
                alu_ctrl_d = ALU_ADD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            p_q        <= '0;
            m_q        <= '0;
            q_q        <= '0;
            product_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_ctrl_q <= ALU_ADD;
        end else begin
            state_q    <= state_d;
            p_q        <= p_d;
            m_q        <= m_d;
            q_q        <= q_d;
            product_q  <= product_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_ctrl_q <= alu_ctrl_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign product     = product_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_control = alu_ctrl_q;

endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  request pulse; sampled only in IDLE.
REQ-004 SHALL have port: op_a  input  32  multiplicand, sampled with accepted start.
REQ-005 SHALL have port: op_b  input  32  multiplier, sampled with accepted start.
REQ-006 SHALL have port: busy  output  1  high whenever state is not IDLE.
REQ-007 SHALL have port: done  output  1  one-cycle pulse, high only in DONE.
REQ-008 SHALL have port: product  output  32  registered low 32 bits of op_a*op_b (unsigned).
REQ-009 SHALL have port: alu_a  output  32  operand A driven to the shared ALU.
REQ-010 SHALL have port: alu_b  output  32  operand B driven to the shared ALU.
REQ-011 SHALL have port: alu_control  output  3  ALU opcode (000 add, 101 shift-left).
REQ-012 SHALL have port: alu_result  input  32  combinational ALU result, same cycle.
REQ-013 SHALL have port: alu_zero  input  1  ALU zero flag; unused, no effect on behaviour.

Function
REQ-014 SHALL hold internal registers P (accumulator, 32b), M (multiplicand, 32b), Q (multiplier, 32b), state (IDLE, ADD, SHF, DONE).
REQ-015 SHALL perform all additions and left shifts through the external ALU; Q right-shift is local logic.
REQ-016 IDLE: alu_a=0, alu_b=0, alu_control=000; start=1 -> P<=0, M<=op_a, Q<=op_b; next state ADD if op_b!=0, else DONE.
REQ-017 ADD: alu_a=P, alu_b=M, alu_control=000; P<=alu_result only if Q[0]=1, else P holds; next state SHF unconditionally.
REQ-018 SHF: alu_a=M, alu_b=32'd1, alu_control=101; M<=alu_result; Q<=Q>>1; next state DONE if (Q>>1)==0, else ADD.
REQ-019 DONE: product<=P written on entry cycle edge (visible with done=1); alu outputs as IDLE; next state IDLE.
REQ-020 Latency: start accepted at edge T; for op_b with highest set bit k, done=1 in cycle T+1+2(k+1); for op_b=0, done=1 in cycle T+1.
REQ-021 Overflow: bits beyond 32 silently discarded (modulo 2^32); no flag.
REQ-022 start while busy (ADD, SHF, DONE) SHALL be ignored; op_a/op_b changes while busy SHALL have no effect.
REQ-023 start in the cycle after DONE (IDLE) SHALL be accepted; back-to-back operations have exactly one IDLE cycle between done and next ADD/DONE.
REQ-024 product SHALL hold its last value from DONE until the next DONE; unchanged during busy.
REQ-025 busy and done SHALL be decoded from registered state only (glitch-free, no combinational path from start).

Reset
REQ-026 reset=1 SHALL asynchronously force state=IDLE, P=0, M=0, Q=0, product=0, busy=0, done=0, alu outputs 0/0/000.
REQ-027 reset asserted mid-operation SHALL abort it; no done pulse, product=0; first start after reset release behaves per REQ-016.

Verification
REQ-028 op_a=3, op_b=5, start at T -> busy T+1..T+7, done=1 only at T+7, product=15.
REQ-029 op_a=0xFFFFFFFF, op_b=2 -> done at T+5, product=0xFFFFFFFE (wrap, no flag).
REQ-030 op_a=0x1234, op_b=0 -> done at T+1, product=0, no ADD/SHF cycles seen on alu_control.
REQ-031 op_a=1, op_b=0x80000000 -> done at T+65, product=0x80000000; alternating 000/101 on alu_control for 64 cycles.
REQ-032 start re-pulsed with op_a=7,op_b=7 during busy of 3*5 -> ignored, product=15; then start in IDLE -> product=49 at T'+7.
REQ-033 reset pulsed at T+3 of 3*5 -> immediate IDLE, busy=0, product=0, no done; subsequent 2*3 -> product=6 at T''+5.
